ctrl_pipe: RTL and testbench
============================

// Module: ctrl_pipe
// PURPOSE
//  Decode-once control pipeline plus hazard unit for the 5-stage MIPS core.
//  Takes the D-stage decoder's bundle and registers it through NSTAGE downstream stages (E,M,W by default).
//  Each stage holds its T_new and counts it down on every advance.
//  Produces stall, D-stage forward selects and per-stage control, A3, PC and BD for the datapath and CP0.
// PARAMETERS
//  NSTAGE  3             downstream stages; index 0 = E, NSTAGE-1 = W
//  CTRL_W  24            width of opaque control bundle (ALU/EXT/LOAD/STR/MDU ops etc.)
//  TN_W    2             width of T_new / T_use fields
//  PC_RST  32'h0000_3000 reset PC held in empty stages
// PORTS
//  clk           in   1              clock, rising edge
//  reset         in   1              synchronous, active-low
//  d_valid       in   1              D holds a real instruction (0 = nop)
//  d_ctrl        in   CTRL_W         decoded control bundle
//  d_rs, d_rt    in   5 each         source register numbers
//  d_a3          in   5              destination register (0 = none)
//  d_t_use_rs/rt in   TN_W each      cycles until rs/rt is consumed
//  d_t_new       in   TN_W           cycles after E-entry until the result is ready
//  d_md          in   1              D is a mult/div/mf/mt instruction
//  d_mdu_start   in   1              D starts the MDU (mult/div)
//  d_pc          in   32             D PC
//  d_bd          in   1              D is in a delay slot
//  mdu_busy      in   1              MDU busy
//  flush         in   1              exception/eret: kill all stages
//  stall         out  1              hold F/D; inject bubble into E
//  fwd_rs_sel    out  2              D rs source: 0 = GRF, k = stage k (1..NSTAGE)
//  fwd_rt_sel    out  2              D rt source: 0 = GRF, k = stage k (1..NSTAGE)
//  valid_q       out  NSTAGE         per-stage valid
//  ctrl_q        out  NSTAGE*CTRL_W  per-stage bundle, stage i at [i*CTRL_W +: CTRL_W]
//  a3_q          out  NSTAGE*5       per-stage destination register
//  tnew_q        out  NSTAGE*TN_W    per-stage remaining T_new
//  pc_q          out  NSTAGE*32      per-stage PC
//  bd_q          out  NSTAGE         per-stage delay-slot flag
//  stall_cnt     out  32             stall cycles (feature only)
//  retire_cnt    out  32             valid W-stage exits (feature only)
// BEHAVIOUR
//  Reset (reset==0 at posedge) sets every stage to: valid 0, ctrl 0, a3 0, tnew 0, pc PC_RST, bd 0; counters 0.
//  Stall and forward outputs are combinational. After reset: stall=0 and both selects are 0.
//  Match at stage k: valid_k && a3_k!=0 && a3_k==reg.
//  stall = 1 if any of:
//   - any matching stage for d_rs has tnew_k > d_t_use_rs;
//   - any matching stage for d_rt has tnew_k > d_t_use_rt;
//   - d_md && (mdu_busy || (valid_q[0] && stage-0 mdu_start)).
//  Stall is qualified by d_valid.
//  fwd_*_sel = nearest (lowest-index) matching stage, but only when its tnew==0.
//   If the nearest match has tnew>0, sel=0; a farther stale match is never selected.
//  Advance rule, every cycle when reset==1:
//   - stage i+1 <= stage i, with tnew decremented, saturating at 0;
//   - stage 0 <= D bundle when !stall, with tnew=d_t_new;
//   - on stall, stage 0 <= bubble: valid 0, ctrl 0, a3 0, tnew 0, but pc=d_pc and bd=d_bd, so EPC stays correct.
//  flush==1 clears valid, ctrl, a3 and tnew in all stages next cycle; pc and bd still shift. flush beats stall.
//  The W stage (NSTAGE-1) drops out on advance. No back-pressure exists downstream of D.
//  Simultaneous reset and flush: reset wins.
// CONFIGURATION
//  `CTRL_PIPE_PERF_EN defined:
//   - stall_cnt increments each cycle stall && !flush;
//   - retire_cnt increments when valid_q[NSTAGE-1];
//   - both wrap at 2^32.
//  Undefined: both counter outputs are tied 0 and no counter flops are built.
// STRUCTURE
//  Shared package/header ctrl_pkg: stage index constants, TN_W, PC_RST, and bundle field offsets within ctrl_q.
//  One sub-module ctrl_stage_reg: a single stage register with bubble/flush/tnew-decrement logic,
//   instantiated NSTAGE times in a generate loop.
//  Hazard compare and forward priority logic live in the top module.
// TESTING
//  1. lw $8 (t_new 2) then add $9,$8,$8 (t_use 0) -> stall=1 for 2 cycles, then fwd_rs_sel=3 and fwd_rt_sel=3, stall=0.
//  2. add $8 (t_new 1) then beq $8 (t_use 0) -> 1 stall cycle, then fwd_rs_sel=2.
//  3. add $8 then sw to $8 in rt (t_use 2) -> no stall; fwd_rt_sel=0 in D; E-stage bundle carries rt.
//  4. Writes to $0 in all stages, D reads $0 -> stall=0, fwd sels 0.
//  5. mult, then mfhi with mdu_busy=1 for 5 cycles -> stall held 5 cycles.
//     Bubbles carry mfhi pc/bd. stall_cnt=5 with PERF_EN.
//  6. flush asserted during a stall -> next cycle valid_q=0 in all stages.
//     reset low mid-stream -> all stages at reset values, pc_q=PC_RST.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: definitions shared by the control pipeline and its stage registers.
//   - default sizes for the pipeline (stage count, bundle width, T_new width)
//   - reset PC held by empty stages
//   - stage index constants and the offset of each stage's bundle inside ctrl_q
package ctrl_pkg;

  localparam int          NSTAGE_DEF = 3;
  localparam int          CTRL_W_DEF = 24;
  localparam int          TN_W_DEF   = 2;
  localparam logic [31:0] PC_RST_DEF = 32'h0000_3000;

  // Stage 0 is E; the last stage (NSTAGE-1) is W.
  localparam int          STG_E      = 0;

  // Bit offset of stage 'stage' inside the flattened ctrl_q bus.
  function automatic int ctrl_off(input int stage, input int ctrl_w);
    return stage * ctrl_w;
  endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// ctrl_stage_reg: one downstream pipeline stage register (E, M or W).
//   Ports:
//     clk, reset      rising-edge clock, synchronous active-low reset
//     kill            load a bubble (valid/ctrl/a3/tnew cleared); pc and bd still load
//     in_*            bundle arriving from the previous stage (or from D)
//     valid_q .. bd_q registered bundle for this stage
//   DEC_TNEW selects whether the incoming T_new is counted down on entry
//   (stages fed from another stage) or taken as-is (the E stage, fed from D).
module ctrl_stage_reg import ctrl_pkg::*; #(
  parameter int          CTRL_W   = CTRL_W_DEF,
  parameter int          TN_W     = TN_W_DEF,
  parameter logic [31:0] PC_RST   = PC_RST_DEF,
  parameter bit          DEC_TNEW = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              kill,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [4:0]        in_a3,
  input  logic [TN_W-1:0]   in_tnew,
  input  logic [31:0]       in_pc,
  input  logic              in_bd,
  output logic              valid_q,
  output logic [CTRL_W-1:0] ctrl_q,
  output logic [4:0]        a3_q,
  output logic [TN_W-1:0]   tnew_q,
  output logic [31:0]       pc_q,
  output logic              bd_q
);

  function automatic logic [TN_W-1:0] tnew_dec(input logic [TN_W-1:0] t);
    if (t == '0) return '0;
    return t - 1'b1;
  endfunction

  logic              valid_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic [4:0]        a3_d;
  logic [TN_W-1:0]   tnew_d;
  logic [31:0]       pc_d;
  logic              bd_d;

  always_comb begin
    valid_d = in_valid;
    ctrl_d  = in_ctrl;
    a3_d    = in_a3;
    tnew_d  = DEC_TNEW ? tnew_dec(in_tnew) : in_tnew;
    pc_d    = in_pc;
    bd_d    = in_bd;
    // A bubble keeps pc/bd so the exception PC of the instruction behind it is
    // still recoverable from this stage.
    if (kill) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      a3_d    = '0;
      tnew_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      a3_q    <= '0;
      tnew_q  <= '0;
      pc_q    <= PC_RST;
      bd_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      a3_q    <= a3_d;
      tnew_q  <= tnew_d;
      pc_q    <= pc_d;
      bd_q    <= bd_d;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: decode-once control pipeline and hazard unit for the 5-stage MIPS core.
//   Registers the D-stage decoded bundle through NSTAGE stages (E, M, W), each
//   stage counting its T_new down as it advances, and derives stall and D-stage
//   forwarding selects from the in-flight destinations.
//   Inputs : clk, reset (sync, active-low), d_* decoded D bundle, mdu_busy, flush
//   Outputs: stall, fwd_rs_sel/fwd_rt_sel (0 = GRF, k = stage k),
//            per-stage valid_q/ctrl_q/a3_q/tnew_q/pc_q/bd_q (stage i at slice i),
//            stall_cnt/retire_cnt performance counters.
//   Build option: define CTRL_PIPE_PERF_EN to build the performance counters;
//   otherwise both counter outputs are tied to zero.
module ctrl_pipe import ctrl_pkg::*; #(
  parameter int          NSTAGE = NSTAGE_DEF,
  parameter int          CTRL_W = CTRL_W_DEF,
  parameter int          TN_W   = TN_W_DEF,
  parameter logic [31:0] PC_RST = PC_RST_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     d_valid,
  input  logic [CTRL_W-1:0]        d_ctrl,
  input  logic [4:0]               d_rs,
  input  logic [4:0]               d_rt,
  input  logic [4:0]               d_a3,
  input  logic [TN_W-1:0]          d_t_use_rs,
  input  logic [TN_W-1:0]          d_t_use_rt,
  input  logic [TN_W-1:0]          d_t_new,
  input  logic                     d_md,
  input  logic                     d_mdu_start,
  input  logic [31:0]              d_pc,
  input  logic                     d_bd,
  input  logic                     mdu_busy,
  input  logic                     flush,
  output logic                     stall,
  output logic [1:0]               fwd_rs_sel,
  output logic [1:0]               fwd_rt_sel,
  output logic [NSTAGE-1:0]        valid_q,
  output logic [NSTAGE*CTRL_W-1:0] ctrl_q,
  output logic [NSTAGE*5-1:0]      a3_q,
  output logic [NSTAGE*TN_W-1:0]   tnew_q,
  output logic [NSTAGE*32-1:0]     pc_q,
  output logic [NSTAGE-1:0]        bd_q,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              retire_cnt
);

  logic              v_s  [NSTAGE];
  logic [CTRL_W-1:0] c_s  [NSTAGE];
  logic [4:0]        a3_s [NSTAGE];
  logic [TN_W-1:0]   tn_s [NSTAGE];
  logic [31:0]       pc_s [NSTAGE];
  logic              bd_s [NSTAGE];

  logic kill_e;
  logic mdu_e_d, mdu_e_q;
  logic stall_rs, stall_rt, md_stall;

  // D -> E boundary: a stalled or flushed D becomes a bubble in E.
  assign kill_e = stall | flush;

  for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
    localparam int OFF = ctrl_off(i, CTRL_W);
    if (i == 0) begin : g_e
      ctrl_stage_reg #(
        .CTRL_W(CTRL_W), .TN_W(TN_W), .PC_RST(PC_RST), .DEC_TNEW(1'b0)
      ) u_reg (
        .clk(clk), .reset(reset), .kill(kill_e),
        .in_valid(d_valid), .in_ctrl(d_ctrl), .in_a3(d_a3), .in_tnew(d_t_new),
        .in_pc(d_pc), .in_bd(d_bd),
        .valid_q(v_s[i]), .ctrl_q(c_s[i]), .a3_q(a3_s[i]), .tnew_q(tn_s[i]),
        .pc_q(pc_s[i]), .bd_q(bd_s[i])
      );
    end else begin : g_ds
      // Stage i-1 -> stage i boundary: advances every cycle, T_new counts down.
      ctrl_stage_reg #(
        .CTRL_W(CTRL_W), .TN_W(TN_W), .PC_RST(PC_RST), .DEC_TNEW(1'b1)
      ) u_reg (
        .clk(clk), .reset(reset), .kill(flush),
        .in_valid(v_s[i-1]), .in_ctrl(c_s[i-1]), .in_a3(a3_s[i-1]), .in_tnew(tn_s[i-1]),
        .in_pc(pc_s[i-1]), .in_bd(bd_s[i-1]),
        .valid_q(v_s[i]), .ctrl_q(c_s[i]), .a3_q(a3_s[i]), .tnew_q(tn_s[i]),
        .pc_q(pc_s[i]), .bd_q(bd_s[i])
      );
    end
    assign valid_q[i]                = v_s[i];
    assign ctrl_q[OFF +: CTRL_W]     = c_s[i];
    assign a3_q[i*5 +: 5]            = a3_s[i];
    assign tnew_q[i*TN_W +: TN_W]    = tn_s[i];
    assign pc_q[i*32 +: 32]          = pc_s[i];
    assign bd_q[i]                   = bd_s[i];
  end

  // The MDU-start flag is only ever inspected in E, so it is tracked for E alone.
  always_comb begin
    mdu_e_d = d_valid & d_mdu_start & ~kill_e;
  end

  always_ff @(posedge clk) begin
    if (!reset) mdu_e_q <= 1'b0;
    else        mdu_e_q <= mdu_e_d;
  end

  // Scanning from the far end down lets the nearest match overwrite the select,
  // so a stale far copy of a register is never forwarded. Stall still looks at
  // every match.
  always_comb begin
    stall_rs   = 1'b0;
    stall_rt   = 1'b0;
    fwd_rs_sel = 2'd0;
    fwd_rt_sel = 2'd0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (v_s[k] && a3_s[k] != 5'd0 && a3_s[k] == d_rs) begin
        if (tn_s[k] > d_t_use_rs) stall_rs = 1'b1;
        fwd_rs_sel = (tn_s[k] == '0) ? 2'(k + 1) : 2'd0;
      end
      if (v_s[k] && a3_s[k] != 5'd0 && a3_s[k] == d_rt) begin
        if (tn_s[k] > d_t_use_rt) stall_rt = 1'b1;
        fwd_rt_sel = (tn_s[k] == '0) ? 2'(k + 1) : 2'd0;
      end
    end
    md_stall = d_md & (mdu_busy | (v_s[STG_E] & mdu_e_q));
    stall    = d_valid & (stall_rs | stall_rt | md_stall);
  end

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] retire_cnt_d, retire_cnt_q;

  always_comb begin
    stall_cnt_d  = stall_cnt_q + {31'd0, stall & ~flush};
    retire_cnt_d = retire_cnt_q + {31'd0, v_s[NSTAGE-1]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign retire_cnt = retire_cnt_q;
`else
  assign stall_cnt  = 32'd0;
  assign retire_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: self-checking bench for ctrl_pipe (default parameters).
//   Directed hazard scenarios plus randomized traffic compared against a
//   behavioural model of the stage contents kept as plain arrays.
`timescale 1ns/1ps
module tb_ctrl_pipe;
  localparam int          NS  = 3;
  localparam int          CW  = 24;
  localparam int          TW  = 2;
  localparam logic [31:0] PCR = 32'h0000_3000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic d_valid = 1'b0, d_md = 1'b0, d_mdu_start = 1'b0, d_bd = 1'b0;
  logic mdu_busy = 1'b0, flush = 1'b0;
  logic [CW-1:0] d_ctrl = '0;
  logic [4:0] d_rs = '0, d_rt = '0, d_a3 = '0;
  logic [TW-1:0] d_t_use_rs = '0, d_t_use_rt = '0, d_t_new = '0;
  logic [31:0] d_pc = '0;
  logic stall;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  logic [NS-1:0] valid_q, bd_q;
  logic [NS*CW-1:0] ctrl_q;
  logic [NS*5-1:0] a3_q;
  logic [NS*TW-1:0] tnew_q;
  logic [NS*32-1:0] pc_q;
  logic [31:0] stall_cnt, retire_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_ctrl(d_ctrl), .d_rs(d_rs), .d_rt(d_rt),
    .d_a3(d_a3), .d_t_use_rs(d_t_use_rs), .d_t_use_rt(d_t_use_rt), .d_t_new(d_t_new),
    .d_md(d_md), .d_mdu_start(d_mdu_start), .d_pc(d_pc), .d_bd(d_bd), .mdu_busy(mdu_busy),
    .flush(flush), .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .valid_q(valid_q), .ctrl_q(ctrl_q), .a3_q(a3_q), .tnew_q(tnew_q), .pc_q(pc_q),
    .bd_q(bd_q), .stall_cnt(stall_cnt), .retire_cnt(retire_cnt)
  );

  // ---------------- behavioural reference model ----------------
  bit          m_valid [NS];
  logic [CW-1:0] m_ctrl [NS];
  int          m_a3    [NS];
  int          m_tnew  [NS];
  logic [31:0] m_pc    [NS];
  bit          m_bd    [NS];
  bit          m_mdu_in_e = 0;
  logic [31:0] m_scnt = 0, m_rcnt = 0;

  function automatic bit m_match(int k, int r);
    return m_valid[k] && m_a3[k] != 0 && m_a3[k] == r;
  endfunction

  function automatic bit m_stall();
    bit s = 0;
    for (int k = 0; k < NS; k++) begin
      if (m_match(k, int'(d_rs)) && m_tnew[k] > int'(d_t_use_rs)) s = 1;
      if (m_match(k, int'(d_rt)) && m_tnew[k] > int'(d_t_use_rt)) s = 1;
    end
    if (d_md && (mdu_busy || (m_valid[0] && m_mdu_in_e))) s = 1;
    return s && d_valid;
  endfunction

  function automatic int m_fwd(int r);
    for (int k = 0; k < NS; k++)
      if (m_match(k, r)) return (m_tnew[k] == 0) ? k + 1 : 0;
    return 0;
  endfunction

  function automatic logic [31:0] exp_scnt();
`ifdef CTRL_PIPE_PERF_EN
    return m_scnt;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_rcnt();
`ifdef CTRL_PIPE_PERF_EN
    return m_rcnt;
`else
    return 32'd0;
`endif
  endfunction

  always @(posedge clk) begin
    bit st;
    st = m_stall();
    if (!reset) begin
      for (int i = 0; i < NS; i++) begin
        m_valid[i] = 0; m_ctrl[i] = '0; m_a3[i] = 0; m_tnew[i] = 0; m_pc[i] = PCR; m_bd[i] = 0;
      end
      m_mdu_in_e = 0; m_scnt = 0; m_rcnt = 0;
    end else begin
      if (m_valid[NS-1]) m_rcnt = m_rcnt + 1;
      if (st && !flush) m_scnt = m_scnt + 1;
      for (int i = NS - 1; i > 0; i--) begin
        m_valid[i] = m_valid[i-1] && !flush;
        m_ctrl[i]  = flush ? '0 : m_ctrl[i-1];
        m_a3[i]    = flush ? 0 : m_a3[i-1];
        m_tnew[i]  = flush ? 0 : (m_tnew[i-1] > 0 ? m_tnew[i-1] - 1 : 0);
        m_pc[i]    = m_pc[i-1];
        m_bd[i]    = m_bd[i-1];
      end
      if (flush || st) begin
        m_valid[0] = 0; m_ctrl[0] = '0; m_a3[0] = 0; m_tnew[0] = 0;
      end else begin
        m_valid[0] = d_valid; m_ctrl[0] = d_ctrl; m_a3[0] = int'(d_a3); m_tnew[0] = int'(d_t_new);
      end
      m_pc[0] = d_pc;
      m_bd[0] = d_bd;
      m_mdu_in_e = d_valid && d_mdu_start && !st && !flush;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_d(input bit v, input int rs, input int rt, input int a3, input int tu_rs,
                       input int tu_rt, input int tn, input bit md, input bit ms,
                       input logic [31:0] pc, input bit bd, input logic [CW-1:0] ctrl);
    d_valid = v; d_rs = 5'(rs); d_rt = 5'(rt); d_a3 = 5'(a3);
    d_t_use_rs = TW'(tu_rs); d_t_use_rt = TW'(tu_rt); d_t_new = TW'(tn);
    d_md = md; d_mdu_start = ms; d_pc = pc; d_bd = bd; d_ctrl = ctrl;
  endtask

  task automatic idle();
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_4000, 0, '0);
    mdu_busy = 0; flush = 0;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < NS + 1; i++) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 0; idle(); flush = 1;
    d_valid = 1; d_pc = 32'h1234_5678;
    tick(); tick();
    reset = 1; idle(); #1;
    checks++; if (valid_q !== '0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_q); end
    checks++; if (pc_q !== {NS{PCR}}) begin errors++; $display("FAIL reset_pc got %h want %h", pc_q, {NS{PCR}}); end
    checks++; if (ctrl_q !== '0 || a3_q !== '0 || tnew_q !== '0 || bd_q !== '0) begin
      errors++; $display("FAIL reset_fields got ctrl %h a3 %h tnew %h bd %b want 0", ctrl_q, a3_q, tnew_q, bd_q); end
    checks++; if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin
      errors++; $display("FAIL reset_comb got stall %b rs %0d rt %0d want 0 0 0", stall, fwd_rs_sel, fwd_rt_sel); end
    checks++; if (stall_cnt !== 32'd0 || retire_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got %0d %0d want 0 0", stall_cnt, retire_cnt); end
  endtask

  task automatic test_load_use();
    set_d(1, 29, 0, 8, 1, 3, 2, 0, 0, 32'h0000_3000, 0, 24'h00_0a01); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_first got %b want 0", stall); end
    tick();
    set_d(1, 8, 8, 9, 0, 0, 1, 0, 0, 32'h0000_3004, 0, 24'h00_0b02); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall1 got %b want 1", stall); end
    tick(); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall2 got %b want 1", stall); end
    checks++; if (valid_q[0] !== 1'b0 || pc_q[31:0] !== 32'h0000_3004) begin
      errors++; $display("FAIL lu_bubble got v %b pc %h want 0 00003004", valid_q[0], pc_q[31:0]); end
    tick(); #1;
    checks++; if (stall !== 1'b0 || fwd_rs_sel !== 2'd3 || fwd_rt_sel !== 2'd3) begin
      errors++; $display("FAIL lu_fwd got stall %b rs %0d rt %0d want 0 3 3", stall, fwd_rs_sel, fwd_rt_sel); end
    tick(); drain();
  endtask

  task automatic test_alu_branch();
    set_d(1, 1, 2, 8, 0, 0, 1, 0, 0, 32'h0000_3010, 0, 24'h00_0c03); tick();
    set_d(1, 8, 9, 0, 0, 0, 0, 0, 0, 32'h0000_3014, 0, 24'h00_0d04); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL br_stall got %b want 1", stall); end
    tick(); #1;
    checks++; if (stall !== 1'b0 || fwd_rs_sel !== 2'd2 || fwd_rt_sel !== 2'd0) begin
      errors++; $display("FAIL br_fwd got stall %b rs %0d rt %0d want 0 2 0", stall, fwd_rs_sel, fwd_rt_sel); end
    tick(); drain();
  endtask

  task automatic test_store_late_use();
    set_d(1, 1, 2, 8, 0, 0, 1, 0, 0, 32'h0000_3020, 0, 24'h00_0e05); tick();
    set_d(1, 29, 8, 0, 1, 2, 0, 0, 0, 32'h0000_3024, 0, 24'h8_0f06); #1;
    checks++; if (stall !== 1'b0 || fwd_rt_sel !== 2'd0) begin
      errors++; $display("FAIL sw_nostall got stall %b rt %0d want 0 0", stall, fwd_rt_sel); end
    tick(); idle(); #1;
    checks++; if (valid_q[0] !== 1'b1 || ctrl_q[CW-1:0] !== 24'h8_0f06) begin
      errors++; $display("FAIL sw_e_bundle got v %b ctrl %h want 1 080f06", valid_q[0], ctrl_q[CW-1:0]); end
    drain();
  endtask

  task automatic test_zero_reg();
    for (int i = 0; i < NS; i++) begin
      set_d(1, 3, 4, 0, 0, 0, 2, 0, 0, 32'h0000_3030 + 4 * i, 0, 24'h00_1000); tick();
    end
    set_d(1, 0, 0, 5, 0, 0, 0, 0, 0, 32'h0000_303c, 0, 24'h00_1001); #1;
    checks++; if (valid_q !== {NS{1'b1}} || stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin
      errors++; $display("FAIL zero_reg got v %b stall %b rs %0d rt %0d want 111 0 0 0", valid_q, stall, fwd_rs_sel, fwd_rt_sel); end
    tick(); drain();
  endtask

  task automatic test_mdu();
    logic [31:0] base;
    set_d(1, 4, 5, 0, 0, 0, 0, 1, 1, 32'h0000_30fc, 0, 24'h00_2000); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mdu_mult got %b want 0", stall); end
    tick();
    set_d(1, 0, 0, 9, 3, 3, 1, 1, 0, 32'h0000_3100, 1, 24'h00_2001);
    mdu_busy = 1;
    base = m_scnt;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mdu_stall_%0d got %b want 1", c, stall); end
      if (c == 1) begin
        checks++; if (valid_q[0] !== 1'b0 || pc_q[31:0] !== 32'h0000_3100 || bd_q[0] !== 1'b1) begin
          errors++; $display("FAIL mdu_bubble got v %b pc %h bd %b want 0 00003100 1", valid_q[0], pc_q[31:0], bd_q[0]); end
      end
      tick();
    end
    mdu_busy = 0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mdu_release got %b want 0", stall); end
`ifdef CTRL_PIPE_PERF_EN
    checks++; if (stall_cnt !== base + 32'd5) begin errors++; $display("FAIL mdu_cnt got %0d want %0d", stall_cnt, base + 32'd5); end
`else
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL mdu_cnt got %0d want 0", stall_cnt); end
`endif
    tick(); drain();
  endtask

  task automatic test_flush_reset();
    set_d(1, 1, 2, 8, 0, 0, 2, 0, 0, 32'h0000_3200, 0, 24'h00_3000); tick();
    set_d(1, 8, 0, 9, 0, 0, 1, 0, 0, 32'h0000_3204, 1, 24'h00_3001); flush = 1; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fl_stall got %b want 1", stall); end
    tick(); idle(); #1;
    checks++; if (valid_q !== '0 || pc_q[31:0] !== 32'h0000_3204 || bd_q[0] !== 1'b1) begin
      errors++; $display("FAIL fl_clear got v %b pc %h bd %b want 000 00003204 1", valid_q, pc_q[31:0], bd_q[0]); end
    for (int i = 0; i < 2; i++) begin
      set_d(1, 1, 2, 10 + i, 0, 0, 2, 0, 0, 32'h0000_3300 + 4 * i, 1, 24'h00_4000); tick();
    end
    reset = 0; flush = 1; tick();
    reset = 1; idle(); #1;
    checks++; if (valid_q !== '0 || pc_q !== {NS{PCR}} || a3_q !== '0 || tnew_q !== '0 || bd_q !== '0 || ctrl_q !== '0) begin
      errors++; $display("FAIL rst_mid got v %b pc %h a3 %h bd %b want 0 %h 0 0", valid_q, pc_q, a3_q, bd_q, {NS{PCR}}); end
    checks++; if (stall_cnt !== 32'd0 || retire_cnt !== 32'd0) begin
      errors++; $display("FAIL rst_mid_cnt got %0d %0d want 0 0", stall_cnt, retire_cnt); end
  endtask

  task automatic test_random();
    logic [NS-1:0] ev;
    logic [NS*5-1:0] ea3;
    logic [NS*TW-1:0] etn;
    logic [NS*32-1:0] epc;
    logic [NS-1:0] ebd;
    logic [NS*CW-1:0] ectl;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) != 0);
      flush = ($urandom_range(0, 19) == 0);
      mdu_busy = ($urandom_range(0, 5) == 0);
      set_d($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 4) == 0, $urandom_range(0, 1), $urandom, $urandom_range(0, 1), CW'($urandom));
      #1;
      checks++; if (stall !== m_stall()) begin errors++; $display("FAIL rnd_stall[%0d] got %b want %b", n, stall, m_stall()); end
      checks++; if (int'(fwd_rs_sel) != m_fwd(int'(d_rs)) || int'(fwd_rt_sel) != m_fwd(int'(d_rt))) begin
        errors++; $display("FAIL rnd_fwd[%0d] got %0d %0d want %0d %0d", n, fwd_rs_sel, fwd_rt_sel, m_fwd(int'(d_rs)), m_fwd(int'(d_rt))); end
      for (int k = 0; k < NS; k++) begin
        ev[k] = m_valid[k]; ea3[k*5 +: 5] = 5'(m_a3[k]); etn[k*TW +: TW] = TW'(m_tnew[k]);
        epc[k*32 +: 32] = m_pc[k]; ebd[k] = m_bd[k]; ectl[k*CW +: CW] = m_ctrl[k];
      end
      checks++; if (valid_q !== ev || a3_q !== ea3 || tnew_q !== etn || pc_q !== epc || bd_q !== ebd || ctrl_q !== ectl) begin
        errors++; $display("FAIL rnd_state[%0d] got v %b a3 %h tn %h bd %b want v %b a3 %h tn %h bd %b",
                           n, valid_q, a3_q, tnew_q, bd_q, ev, ea3, etn, ebd); end
      checks++; if (stall_cnt !== exp_scnt() || retire_cnt !== exp_rcnt()) begin
        errors++; $display("FAIL rnd_cnt[%0d] got %0d %0d want %0d %0d", n, stall_cnt, retire_cnt, exp_scnt(), exp_rcnt()); end
      tick();
    end
    reset = 1; drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    test_reset();
    test_load_use();
    test_alu_branch();
    test_store_late_use();
    test_zero_reg();
    test_mdu();
    test_flush_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
